mem_load_store_unit: RTL and testbench

//  MEM-stage initiator for the data-memory port: accepts one load/store per instruction from the
//  EX/MEM pipeline register and drives a word-wide req/ack data-memory interface.
//  Big-endian byte lanes: the byte at offset 0 is bits [31:24]. Aligns and replicates store data,

---
 rtl/mem_load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store initiator: aligns store data, builds big-endian byte enables,
// formats load data and stalls the pipeline across a req/ack data-memory handshake.
module mem_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        load_done,
    output logic        stall,
    output logic        addr_error,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          load_done_q, load_done_d;
    logic          addr_error_q, addr_error_d;
    logic          bus_error_q, bus_error_d;

    logic          op_valid;
    logic          aligned;
    logic          timeout_hit;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [15:0]   half_lane;
    logic [7:0]    byte_lane;
    logic [31:0]   load_fmt;

    always_comb begin
        op_valid  = mem_read | mem_write;
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = write_data;
        case (load_mode)
            2'b00: begin
                aligned   = (address[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = write_data;
            end
            2'b01, 2'b10: begin
                aligned   = ~address[0];
                be_new    = address[1] ? 4'b0011 : 4'b1100;
                wdata_new = {2{write_data[15:0]}};
            end
            default: begin
                aligned   = 1'b1;
                be_new    = 4'b1000 >> address[1:0];
                wdata_new = {4{write_data[7:0]}};
            end
        endcase
    end

    // Load lane selection uses the latched offset/mode, since the pipeline inputs may change mid-access
    always_comb begin
        half_lane = addr_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (addr_q[1:0])
            2'b00:   byte_lane = dmem_rdata[31:24];
            2'b01:   byte_lane = dmem_rdata[23:16];
            2'b10:   byte_lane = dmem_rdata[15:8];
            default: byte_lane = dmem_rdata[7:0];
        endcase
        case (mode_q)
            2'b00:   load_fmt = dmem_rdata;
            2'b01:   load_fmt = {{16{half_lane[15]}}, half_lane};
            2'b10:   load_fmt = {16'h0000, half_lane};
            default: load_fmt = {24'h000000, byte_lane};
        endcase
    end

    always_comb begin
        timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        read_data_d  = read_data_q;
        load_done_d  = 1'b0;
        addr_error_d = 1'b0;
        bus_error_d  = 1'b0;
        stall        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (op_valid) begin
                    if (!aligned) begin
                        addr_error_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = address;
                        mode_d  = load_mode;
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack) begin
                    if (!we_q) begin
                        read_data_d = load_fmt;
                    end
                    load_done_d = 1'b1;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            mode_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            read_data_q  <= '0;
            load_done_q  <= 1'b0;
            addr_error_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            read_data_q  <= read_data_d;
            load_done_q  <= load_done_d;
            addr_error_q <= addr_error_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign read_data  = read_data_q;
    assign load_done  = load_done_q;
    assign addr_error = addr_error_q;
    assign bus_error  = bus_error_q;
    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Bench for mem_load_store_unit: directed cases plus random loads/stores against a
// byte-addressed memory model, with the bench acting as the data-memory responder.
module tb_mem_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_mode;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        load_done;
    logic        stall;
    logic        addr_error;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [int unsigned];
    logic [31:0] exp_read_data = 32'h0;

    mem_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .load_mode  (load_mode),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .load_done  (load_done),
        .stall      (stall),
        .addr_error (addr_error),
        .bus_error  (bus_error),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int size_of(input logic [1:0] mode);
        if (mode == 2'b00) return 4;
        if (mode == 2'b11) return 1;
        return 2;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] mode, input int k);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < size_of(mode); i++) be[3 - (k + i)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] mode, input logic [31:0] wd);
        if (size_of(mode) == 4) return wd;
        if (size_of(mode) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return (wd & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] byte_at(input logic [31:0] word, input int j);
        return (word >> (8 * (3 - j))) & 32'hFF;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] mode, input int k, input logic [31:0] word);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < size_of(mode); i++) v = (v << 8) | byte_at(word, k + i);
        if (mode == 2'b01 && v >= 32'h8000) v = v - 32'h1_0000;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] waddr);
        if (!mem.exists(waddr)) mem[waddr] = $urandom;
        return mem[waddr];
    endfunction

    // latency < 0 means the responder never acks and a timeout is expected
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] mode,
                                  input logic [31:0] addr, input logic [31:0] wd, input int latency);
        logic [31:0] waddr = {addr[31:2], 2'b00};
        int          k     = int'(addr[1:0]);
        int          busy_cycles = (latency < 0) ? 4 : latency + 1;
        logic [31:0] word;
        logic [31:0] exp_wd = model_wdata(mode, wd);
        logic [3:0]  exp_be = model_be(mode, k);
        @(negedge clk);
        mem_read = rd; mem_write = wr; load_mode = mode; address = addr; write_data = wd;
        #1;
        check_output("stall_accept", stall, 1);
        check_output("req_before_busy", dmem_req, 0);
        for (int c = 0; c < busy_cycles; c++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            check_output("busy_req", dmem_req, 1);
            check_output("busy_stall", stall, 1);
            check_output("busy_addr", dmem_addr, waddr);
            check_output("busy_be", dmem_be, exp_be);
            check_output("busy_we", dmem_we, wr);
            if (wr) check_output("busy_wdata", dmem_wdata, exp_wd);
            if (c == latency) begin
                word = mem_word(waddr);
                dmem_ack = 1'b1;
                dmem_rdata = wr ? $urandom : word;
                if (wr) begin
                    for (int j = 0; j < 4; j++)
                        if (exp_be[3 - j]) begin
                            word = word & ~(32'hFF << (8 * (3 - j)));
                            word = word | (byte_at(exp_wd, j) << (8 * (3 - j)));
                        end
                    mem[waddr] = word;
                end else begin
                    exp_read_data = model_load(mode, k, word);
                end
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        check_output("done_load_done", load_done, (latency >= 0) ? 1 : 0);
        check_output("done_bus_error", bus_error, (latency < 0) ? 1 : 0);
        check_output("done_stall", stall, 0);
        check_output("done_req", dmem_req, 0);
        check_output("read_data", read_data, exp_read_data);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check_output("idle_req", dmem_req, 0);
        check_output("idle_pulses", {load_done, bus_error, addr_error}, 0);
    endtask

    task automatic do_misaligned(input logic [1:0] mode, input logic [31:0] addr);
        @(negedge clk);
        mem_read = 1'b1; load_mode = mode; address = addr;
        #1;
        check_output("mis_stall", stall, 0);
        @(negedge clk);
        check_output("mis_addr_error", addr_error, 1);
        check_output("mis_req", dmem_req, 0);
        mem_read = 1'b0;
        @(negedge clk);
        check_output("mis_pulse_end", addr_error, 0);
        check_output("mis_req_after", dmem_req, 0);
        check_output("mis_read_data", read_data, exp_read_data);
    endtask

    initial begin
        logic [1:0]  mode;
        logic [31:0] addr;
        int          sel;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; load_mode = 2'b00;
        address = 32'h0; write_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_outputs", {read_data, dmem_addr, dmem_wdata} == 96'h0 ? 0 : 1, 0);
        check_output("rst_flags", {load_done, stall, addr_error, bus_error, dmem_req, dmem_we, dmem_be}, 0);

        mem[32'h100] = 32'hDEAD_BEEF;
        apply_stimulus(1, 0, 2'b00, 32'h100, 32'h0, 0);
        check_output("word_load_value", read_data, 32'hDEAD_BEEF);
        mem[32'h100] = 32'h1234_F00D;
        apply_stimulus(1, 0, 2'b01, 32'h102, 32'h0, 1);
        check_output("half_signed_value", read_data, 32'hFFFF_F00D);
        apply_stimulus(1, 0, 2'b10, 32'h102, 32'h0, 0);
        check_output("half_unsigned_value", read_data, 32'h0000_F00D);
        apply_stimulus(0, 1, 2'b11, 32'h203, 32'h0000_00A5, 0);
        check_output("byte_store_mem", mem[32'h200] & 32'hFF, 32'hA5);

        do_misaligned(2'b00, 32'h101);
        do_misaligned(2'b01, 32'h103);

        apply_stimulus(1, 0, 2'b00, 32'h500, 32'h0, -1);

        for (int n = 0; n < 60; n++) begin
            mode = 2'($urandom_range(0, 3));
            addr = 32'h300 + 32'($urandom_range(0, 3)) * 4;
            if (mode == 2'b11) addr = addr + 32'($urandom_range(0, 3));
            else if (mode != 2'b00) addr = addr + 32'($urandom_range(0, 1)) * 2;
            sel = $urandom_range(0, 4);
            apply_stimulus(sel <= 1 || sel == 4, sel >= 2, mode, addr, $urandom, $urandom_range(0, 2));
        end

        // Reset mid-access followed by a stray ack
        @(negedge clk);
        mem_read = 1'b1; load_mode = 2'b00; address = 32'h600;
        @(negedge clk);
        check_output("pre_rst_req", dmem_req, 1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_read_data = 32'h0;
        check_output("rst_busy_req", dmem_req, 0);
        check_output("rst_busy_data", read_data, 32'h0);
        check_output("rst_busy_flags", {load_done, stall, bus_error, dmem_we, dmem_be}, 0);
        check_output("rst_busy_addr", dmem_addr, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        check_output("late_ack_done", load_done, 0);
        check_output("late_ack_req", dmem_req, 0);
        check_output("late_ack_data", read_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
